mmio_hub: RTL

//  Parametrised memory-mapped I/O hub between CPU load/store stage and board peripherals.

---
 rtl/mmio_hub_pkg.sv | 28 ++
 rtl/mmio_hub_if.sv | 20 ++
 rtl/mmio_hub_edge_event.sv | 36 +++
 rtl/mmio_hub.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mmio_hub_pkg.sv
// Shared IO map for the MMIO hub: window base, register offsets, STATUS bit layout.
package mmio_hub_pkg;

    localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_F000;

    localparam logic [7:0] OFF_SW     = 8'h00;
    localparam logic [7:0] OFF_KEY    = 8'h40;
    localparam logic [7:0] OFF_STATUS = 8'h44;
    localparam logic [7:0] OFF_TIMER  = 8'h48;
    localparam logic [7:0] OFF_CMP    = 8'h4C;
    localparam logic [7:0] OFF_LED    = 8'h60;
    localparam logic [7:0] OFF_SEG    = 8'h80;

    localparam int ST_BTN_PEND = 0;
    localparam int ST_TMR_HIT  = 1;

    typedef struct packed {
        logic       hit;
        logic       rd;
        logic       wr;
        logic [7:0] off;
    } io_req_t;

    function automatic logic io_window_hit(input logic [23:0] page, input logic [23:0] base_page);
        return page == base_page;
    endfunction

endpackage

// File: rtl/mmio_hub_if.sv
// CPU-side load/store bus into the hub: the CPU is master, the hub is slave.
interface mmio_hub_if;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic        mem_sel;
    logic [31:0] io_rdata;
    logic        io_rvalid;

    modport master (
        output addr, rd_en, wr_en, wdata,
        input  mem_sel, io_rdata, io_rvalid
    );

    modport slave (
        input  addr, rd_en, wr_en, wdata,
        output mem_sel, io_rdata, io_rvalid
    );
endinterface

// File: rtl/mmio_hub_edge_event.sv
// Async level -> 2-flop synchroniser -> rising-edge detect -> sticky flag; a new edge beats a clear.
module edge_event (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    input  logic clr_i,
    output logic flag_o
);
    logic s1_q, s2_q, s3_q;
    logic flag_q, flag_d;

    always_comb begin
        flag_d = flag_q;
        if (s2_q & ~s3_q) begin
            flag_d = 1'b1;
        end else if (clr_i) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            s1_q   <= in_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;
endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: splits CPU accesses into DMem vs IO and owns switch/key/button/timer/LED/seg registers.
module mmio_hub
    import mmio_hub_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEF,
    parameter int          NUM_SW  = 2,
    parameter int          SW_W    = 12,
    parameter int          NUM_LED = 1,
    parameter int          LED_W   = 16,
    parameter int          TIMER_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    mmio_hub_if.slave                bus,
    input  logic [NUM_SW*SW_W-1:0]   sw_i,
    input  logic [31:0]              key_i,
    input  logic                     btn_i,
    output logic [NUM_LED*LED_W-1:0] led_o,
    output logic [31:0]              seg_o,
    output logic                     seg_upd_o
);
    io_req_t req;

    always_comb begin
        req.hit = io_window_hit(bus.addr[31:8], IO_BASE[31:8]);
        req.wr  = bus.wr_en & req.hit;
        // a store wins over a simultaneous load; the load gets no response
        req.rd  = bus.rd_en & ~bus.wr_en & req.hit;
        req.off = {bus.addr[7:2], 2'b00};
    end

    assign bus.mem_sel = ~req.hit;

    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    logic [NUM_SW*SW_W-1:0]   sw_s1_q, sw_s2_q;
    logic [TIMER_W-1:0]       timer_q, timer_d, cmp_q, cmp_d;
    logic                     tmr_hit_q, tmr_hit_d;
    logic [NUM_LED*LED_W-1:0] led_q, led_d;
    logic [31:0]              seg_q, seg_d;
    logic                     seg_upd_q, seg_upd_d;
    logic [31:0]              io_rdata_q, rdata_mux, status;
    logic                     io_rvalid_q;
    logic                     status_rd;
    logic                     btn_pend;

    assign status_rd = req.rd && (req.off == OFF_STATUS);

    edge_event u_btn (
        .clk    (clk),
        .rst    (rst),
        .in_i   (btn_i),
        .clr_i  (status_rd),
        .flag_o (btn_pend)
    );

    // hit is flagged on the edge where the timer reaches CMP, so it is visible while timer==CMP
    always_comb begin
        timer_d   = timer_q + TIMER_W'(1);
        cmp_d     = cmp_q;
        if (req.wr && req.off == OFF_TIMER) timer_d = bus.wdata[TIMER_W-1:0];
        if (req.wr && req.off == OFF_CMP)   cmp_d   = bus.wdata[TIMER_W-1:0];
        tmr_hit_d = tmr_hit_q;
        if (timer_d == cmp_d) begin
            tmr_hit_d = 1'b1;
        end else if (status_rd) begin
            tmr_hit_d = 1'b0;
        end
    end

    always_comb begin
        led_d     = led_q;
        for (int j = 0; j < NUM_LED; j++) begin
            if (req.wr && req.off == OFF_LED + 8'(4 * j)) led_d[j*LED_W +: LED_W] = bus.wdata[LED_W-1:0];
        end
        seg_upd_d = req.wr && (req.off == OFF_SEG);
        seg_d     = seg_upd_d ? bus.wdata : seg_q;
    end

    always_comb begin
        status              = '0;
        status[ST_BTN_PEND] = btn_pend;
        status[ST_TMR_HIT]  = tmr_hit_q;
        rdata_mux           = '0;
        case (req.off)
            OFF_KEY:    rdata_mux = key_i;
            OFF_STATUS: rdata_mux = status;
            OFF_TIMER:  rdata_mux = 32'(timer_q);
            OFF_CMP:    rdata_mux = 32'(cmp_q);
            OFF_SEG:    rdata_mux = seg_q;
            default:    rdata_mux = '0;
        endcase
        for (int i = 0; i < NUM_SW; i++) begin
            if (req.off == OFF_SW + 8'(4 * i)) rdata_mux = 32'(sw_s2_q[i*SW_W +: SW_W]);
        end
        for (int j = 0; j < NUM_LED; j++) begin
            if (req.off == OFF_LED + 8'(4 * j)) rdata_mux = 32'(led_q[j*LED_W +: LED_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            timer_q     <= '0;
            cmp_q       <= '1;
            tmr_hit_q   <= 1'b0;
            led_q       <= '0;
            seg_q       <= '0;
            seg_upd_q   <= 1'b0;
            io_rdata_q  <= '0;
            io_rvalid_q <= 1'b0;
        end else begin
            sw_s1_q     <= sw_i;
            sw_s2_q     <= sw_s1_q;
            timer_q     <= timer_d;
            cmp_q       <= cmp_d;
            tmr_hit_q   <= tmr_hit_d;
            led_q       <= led_d;
            seg_q       <= seg_d;
            seg_upd_q   <= seg_upd_d;
            io_rvalid_q <= req.rd;
            if (req.rd) io_rdata_q <= rdata_mux;
        end
    end

    assign bus.io_rdata  = io_rdata_q;
    assign bus.io_rvalid = io_rvalid_q;
    assign led_o         = led_q;
    assign seg_o         = seg_q;
    assign seg_upd_o     = seg_upd_q;
endmodule
